// File: rtl/iir_biquad_sequencer.sv
// Time-multiplexed sequencer for a cascade of NSEC biquad sections sharing
// one multiply/saturating-accumulate datapath. For each accepted sample it
// walks every section through five MAC taps and one write-back cycle, then
// strobes the final output. Saturation events are gathered into a sticky flag.
//
// Handshake: a sample is taken on a rising edge where in_valid & in_ready &
// clk_enable are all high and flush is low. in_ready is high only while the
// sequencer is idle; nothing is queued, so in_valid outside idle is ignored.
//
// Control outputs are registered decodes of the state held during the
// previous cycle, so the first MAC cycle appears one cycle after the accept
// edge. clk_enable=0 freezes every register; consumers qualify strobes with it.
module iir_biquad_sequencer #(
    parameter int NSEC    = 4,
    parameter int COEF_AW = 6,
    parameter int SEC_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic               ovf_in,
    input  logic               ovf_clr,
    output logic [COEF_AW-1:0] coef_addr,
    output logic [2:0]         op_sel,
    output logic               acc_clr,
    output logic               acc_en,
    output logic [SEC_W-1:0]   sec_idx,
    output logic               state_we,
    output logic               out_valid,
    output logic               busy,
    output logic               ovf_sticky
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [2:0]       LAST_TAP = 3'd4;
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NSEC - 1);

    state_e             state_q, state_d;
    logic [2:0]         tap_q, tap_d;
    logic [SEC_W-1:0]   sec_q, sec_d;

    logic [COEF_AW-1:0] coef_addr_q, coef_addr_d;
    logic [2:0]         op_sel_q, op_sel_d;
    logic               acc_clr_q, acc_clr_d;
    logic               acc_en_q, acc_en_d;
    logic [SEC_W-1:0]   sec_idx_q, sec_idx_d;
    logic               state_we_q, state_we_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;

    logic               active;
    logic               abort;
    logic [COEF_AW-1:0] mac_addr;

    assign active   = (state_q != S_IDLE);
    assign abort    = flush && active;
    assign mac_addr = COEF_AW'(5) * COEF_AW'(sec_q) + COEF_AW'(tap_q);

    // Next-state logic: tap/section counters and the phase of the walk.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        sec_d   = sec_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    state_d = S_MAC;
                    tap_d   = 3'd0;
                    sec_d   = '0;
                end
            end
            S_MAC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (tap_q == LAST_TAP) begin
                    state_d = S_WB;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            S_WB: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (sec_q == LAST_SEC) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MAC;
                    tap_d   = 3'd0;
                    sec_d   = sec_q + SEC_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode of the current state; an abort registers idle values.
    always_comb begin
        coef_addr_d = '0;
        op_sel_d    = 3'd0;
        acc_clr_d   = 1'b0;
        acc_en_d    = 1'b0;
        sec_idx_d   = '0;
        state_we_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (!abort) begin
            case (state_q)
                S_MAC: begin
                    coef_addr_d = mac_addr;
                    op_sel_d    = tap_q;
                    acc_en_d    = 1'b1;
                    acc_clr_d   = (tap_q == 3'd0);
                    sec_idx_d   = sec_q;
                    busy_d      = 1'b1;
                end
                S_WB: begin
                    coef_addr_d = mac_addr;
                    op_sel_d    = tap_q;
                    sec_idx_d   = sec_q;
                    state_we_d  = 1'b1;
                    busy_d      = 1'b1;
                end
                S_DONE: begin
                    sec_idx_d   = sec_q;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
                default: begin
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a set during MAC/WB beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_in && (state_q == S_MAC || state_q == S_WB)) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State and output registers, frozen while clk_enable is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tap_q       <= 3'd0;
            sec_q       <= '0;
            coef_addr_q <= '0;
            op_sel_q    <= 3'd0;
            acc_clr_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            sec_idx_q   <= '0;
            state_we_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (clk_enable) begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            sec_q       <= sec_d;
            coef_addr_q <= coef_addr_d;
            op_sel_q    <= op_sel_d;
            acc_clr_q   <= acc_clr_d;
            acc_en_q    <= acc_en_d;
            sec_idx_q   <= sec_idx_d;
            state_we_q  <= state_we_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign coef_addr  = coef_addr_q;
    assign op_sel     = op_sel_q;
    assign acc_clr    = acc_clr_q;
    assign acc_en     = acc_en_q;
    assign sec_idx    = sec_idx_q;
    assign state_we   = state_we_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Bench for iir_biquad_sequencer. A reference model computes, for every
// accepted sample, the full schedule of strobes from the cycle arithmetic
// (section k, tap r at offset 6k+r+1; write-back at 6k+6; output at 6N+1)
// and pushes it into a queue; a monitor pops and compares each strobe the
// DUT presents. Times are counted in enabled clock edges.
module tb_iir_biquad_sequencer;
  localparam int NSEC    = 4;
  localparam int COEF_AW = 6;
  localparam int SEC_W   = 3;
  localparam int EXP_W   = 32 + 2 + COEF_AW + 3 + 1 + SEC_W;
  localparam int K_MAC   = 0;
  localparam int K_WB    = 1;
  localparam int K_OUT   = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               clk_enable = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               flush = 1'b0;
  logic               ovf_in = 1'b0;
  logic               ovf_clr = 1'b0;
  logic [COEF_AW-1:0] coef_addr;
  logic [2:0]         op_sel;
  logic               acc_clr;
  logic               acc_en;
  logic [SEC_W-1:0]   sec_idx;
  logic               state_we;
  logic               out_valid;
  logic               busy;
  logic               ovf_sticky;

  iir_biquad_sequencer #(
    .NSEC   (NSEC),
    .COEF_AW(COEF_AW),
    .SEC_W  (SEC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .ovf_in    (ovf_in),
    .ovf_clr   (ovf_clr),
    .coef_addr (coef_addr),
    .op_sel    (op_sel),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .sec_idx   (sec_idx),
    .state_we  (state_we),
    .out_valid (out_valid),
    .busy      (busy),
    .ovf_sticky(ovf_sticky)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;
  bit inflight    = 1'b0;
  int end_edge    = 0;
  bit ovf_exp     = 1'b0;
  bit busy_exp    = 1'b0;

  function automatic logic [EXP_W-1:0] mk(int t, int kind, int coef, int op, bit clr, int sec);
    return {32'(t), 2'(kind), COEF_AW'(coef), 3'(op), clr, SEC_W'(sec)};
  endfunction

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h edge=%0d t=%0t", name, got, exp, edge_n, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or negedge reset) begin
    logic [EXP_W-1:0] tail;
    bit pre_mac;
    int k;
    int r;
    if (!reset) begin
      exp_q.delete();
      inflight = 1'b0;
      ovf_exp  = 1'b0;
      busy_exp = 1'b0;
    end else if (clk_enable) begin
      edge_n++;
      pre_mac = inflight && (edge_n <= end_edge);
      if (ovf_in && pre_mac) ovf_exp = 1'b1;
      else if (ovf_clr) ovf_exp = 1'b0;
      if (inflight && flush) begin
        while (exp_q.size() > 0) begin
          tail = exp_q[exp_q.size()-1];
          if (int'(tail[EXP_W-1 -: 32]) >= edge_n) void'(exp_q.pop_back());
          else break;
        end
        inflight = 1'b0;
        busy_exp = 1'b0;
      end else if (inflight) begin
        busy_exp = 1'b1;
        if (edge_n == end_edge + 1) inflight = 1'b0;
      end else begin
        busy_exp = 1'b0;
        if (in_valid && !flush) begin
          inflight = 1'b1;
          end_edge = edge_n + 6 * NSEC;
          for (int j = 1; j <= 6 * NSEC + 1; j++) begin
            k = (j - 1) / 6;
            r = (j - 1) % 6;
            if (j == 6 * NSEC + 1) exp_q.push_back(mk(edge_n + j, K_OUT, 0, 0, 1'b0, 0));
            else if (r < 5) exp_q.push_back(mk(edge_n + j, K_MAC, 5 * k + r, r, (r == 0), k));
            else exp_q.push_back(mk(edge_n + j, K_WB, 0, 0, 1'b0, k));
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [63:0] got_v;
    logic [63:0] exp_v;
    int kind;
    if (!reset) begin
      chk("reset_outs", {coef_addr, op_sel, acc_clr, acc_en, sec_idx, state_we, out_valid, busy, ovf_sticky}, 64'd0);
      chk("reset_in_ready", in_ready, 64'd1);
    end else begin
      chk("in_ready", in_ready, !inflight);
      chk("busy", busy, busy_exp);
      chk("ovf_sticky", ovf_sticky, ovf_exp);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (int'(e[EXP_W-1 -: 32]) < edge_n) begin
          vectors++;
          miscompares++;
          $display("FAIL missed_strobe got=none exp=%0h edge=%0d", e, edge_n);
          void'(exp_q.pop_front());
        end
      end
      if (clk_enable && (acc_en || state_we || out_valid)) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe got en=%0b we=%0b ov=%0b exp=none edge=%0d",
                   acc_en, state_we, out_valid, edge_n);
        end else begin
          e = exp_q.pop_front();
          kind = int'(e[EXP_W-33 -: 2]);
          exp_v = {16'd0, e[EXP_W-1 -: 32], (kind == K_MAC), (kind == K_WB), (kind == K_OUT),
                   (kind == K_MAC) ? e[COEF_AW+6 : 7] : COEF_AW'(0),
                   (kind == K_MAC) ? e[SEC_W+3 : SEC_W+1] : 3'd0,
                   e[SEC_W],
                   (kind != K_OUT) ? e[SEC_W-1:0] : SEC_W'(0)};
          got_v = {16'd0, 32'(edge_n), acc_en, state_we, out_valid,
                   (kind == K_MAC) ? coef_addr : COEF_AW'(0),
                   (kind == K_MAC) ? op_sel : 3'd0,
                   acc_clr,
                   (kind != K_OUT) ? sec_idx : SEC_W'(0)};
          chk("strobe", got_v, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit iv, input bit fl, input bit ce, input bit ov, input bit oc);
    in_valid   = iv;
    flush      = fl;
    clk_enable = ce;
    ovf_in     = ov;
    ovf_clr    = oc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // single sample, full schedule
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(30);

    // in_valid held high: accepts every 6N+2 cycles
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(30);

    // flush during section 1, tap 2, then a new sample right after
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 9; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(30);

    // clock enable low for cycles 3..7 of a sample
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i <= 7; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(30);

    // overflow: pulse in MAC, set+clear together, clear, pulse while idle
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(25);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);

    // reset mid-sample, then a clean sample
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(14);
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(30);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0);
    end

    // drain and confirm nothing is left outstanding
    idle(40);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
